// File: rtl/ram16x8_access_ctrl.sv
// Arbitrates one 16x8 synchronous RAM between a user read/write port and a prescaled
// 4-digit display scanner. Optional write protection (wp, usr_err) under RAMCTL_WR_PROTECT_EN.
module ram16x8_access_ctrl #(
  parameter int DIV_BITS = 20,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_ack,
  output logic [DATA_W-1:0] usr_rdata,
  input  logic [1:0]        disp_page,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [3:0]        disp_an,
  output logic [DATA_W-1:0] disp_data,
  output logic              scan_miss
`ifdef RAMCTL_WR_PROTECT_EN
  ,
  input  logic              wp,
  output logic              usr_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    USR_ACC,
    USR_WAIT,
    SCAN_ACC,
    SCAN_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic                tick;
  logic                pend_q, pend_d;
  logic                miss_q, miss_d;
  logic [1:0]          idx_q, idx_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [3:0]          an_q, an_d;
  logic [DATA_W-1:0]   ddata_q, ddata_d;
  logic                wr_q, wr_d;
  logic                wr_allow;

`ifdef RAMCTL_WR_PROTECT_EN
  logic blk_q, blk_d;
  logic err_q, err_d;
  assign wr_allow = ~wp;
`else
  assign wr_allow = 1'b1;
`endif

  assign tick = &div_q;

  always_comb begin
    // NOTE: every _d defaults to its hold value first, so no branch can infer a latch.
    state_d = state_q;
    div_d   = div_q + DIV_BITS'(1);
    pend_d  = pend_q;
    miss_d  = miss_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    din_d   = din_q;
    an_d    = an_q;
    ddata_d = ddata_q;
    wr_d    = wr_q;
`ifdef RAMCTL_WR_PROTECT_EN
    blk_d   = blk_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = SCAN_ACC;
          addr_d  = {disp_page, idx_q};
        end else if (usr_req && !ack_q) begin
          // Address/strobe are registered here so they are on the pins during USR_ACC.
          state_d = USR_ACC;
          addr_d  = usr_addr;
          wr_d    = usr_we;
          if (usr_we && wr_allow) begin
            we_d  = 1'b1;
            din_d = usr_wdata;
          end
`ifdef RAMCTL_WR_PROTECT_EN
          blk_d = usr_we && !wr_allow;
`endif
        end
      end
      USR_ACC:  state_d = USR_WAIT;
      USR_WAIT: begin
        if (!wr_q) rdata_d = ram_dout;
        ack_d   = 1'b1;
`ifdef RAMCTL_WR_PROTECT_EN
        err_d   = blk_q;
`endif
        state_d = IDLE;
      end
      SCAN_ACC: begin
        pend_d  = 1'b0;
        state_d = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        ddata_d = ram_dout;
        an_d    = ~(4'b0001 << idx_q);
        idx_d   = idx_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new tick always re-arms the scan; a tick on a still-pending scan is a miss.
    if (tick) begin
      pend_d = 1'b1;
      if (pend_q) miss_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      div_q   <= '0;
      pend_q  <= 1'b0;
      miss_q  <= 1'b0;
      idx_q   <= 2'd0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      an_q    <= 4'b1111;
      ddata_q <= '0;
      wr_q    <= 1'b0;
`ifdef RAMCTL_WR_PROTECT_EN
      blk_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      an_q    <= an_d;
      ddata_q <= ddata_d;
      wr_q    <= wr_d;
`ifdef RAMCTL_WR_PROTECT_EN
      blk_q   <= blk_d;
      err_q   <= err_d;
`endif
    end
  end

  assign usr_ack   = ack_q;
  assign usr_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_din   = din_q;
  assign disp_an   = an_q;
  assign disp_data = ddata_q;
  assign scan_miss = miss_q;
`ifdef RAMCTL_WR_PROTECT_EN
  assign usr_err   = err_q;
`endif

endmodule

// File: tb/tb_ram16x8_access_ctrl.sv
// Directed bench: main instance (DIV_BITS=4) with a RAM model, plus two streaming
// instances (DIV_BITS=3 and 2) exercising scan servicing and the sticky scan_miss flag.
module tb_ram16x8_access_ctrl;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       usr_req = 1'b0, usr_we = 1'b0;
  logic [3:0] usr_addr = 4'h0;
  logic [7:0] usr_wdata = 8'h00;
  logic [1:0] disp_page = 2'b00;
  logic       wp_drv = 1'b0;
  logic       usr_ack, ram_we, scan_miss;
  logic [7:0] usr_rdata, ram_din, disp_data;
  logic [7:0] ram_dout;
  logic [3:0] ram_addr, disp_an;
`ifdef RAMCTL_WR_PROTECT_EN
  logic       usr_err, err_b, err_c;
`endif

  logic       clr_s = 1'b1, req_s = 1'b1;
  logic       ack_b, we_b, miss_b, ack_c, we_c, miss_c;
  logic [7:0] rdata_b, din_b, data_b, rdata_c, din_c, data_c;
  logic [3:0] addr_b, an_b, addr_c, an_c;

  logic [7:0] mem [16];
  int cyc;
  int checks = 0;
  int errors = 0;

  ram16x8_access_ctrl #(.DIV_BITS(4)) dut (
    .clk(clk), .clr(clr), .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_ack(usr_ack), .usr_rdata(usr_rdata), .disp_page(disp_page),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .disp_an(disp_an), .disp_data(disp_data), .scan_miss(scan_miss)
`ifdef RAMCTL_WR_PROTECT_EN
    , .wp(wp_drv), .usr_err(usr_err)
`endif
  );

  ram16x8_access_ctrl #(.DIV_BITS(3)) dut_b (
    .clk(clk), .clr(clr_s), .usr_req(req_s), .usr_we(1'b0), .usr_addr(4'h2),
    .usr_wdata(8'h00), .usr_ack(ack_b), .usr_rdata(rdata_b), .disp_page(2'b00),
    .ram_addr(addr_b), .ram_we(we_b), .ram_din(din_b), .ram_dout(8'h00),
    .disp_an(an_b), .disp_data(data_b), .scan_miss(miss_b)
`ifdef RAMCTL_WR_PROTECT_EN
    , .wp(1'b0), .usr_err(err_b)
`endif
  );

  ram16x8_access_ctrl #(.DIV_BITS(2)) dut_c (
    .clk(clk), .clr(clr_s), .usr_req(req_s), .usr_we(1'b0), .usr_addr(4'h2),
    .usr_wdata(8'h00), .usr_ack(ack_c), .usr_rdata(rdata_c), .disp_page(2'b00),
    .ram_addr(addr_c), .ram_we(we_c), .ram_din(din_c), .ram_dout(8'h00),
    .disp_an(an_c), .disp_data(data_c), .scan_miss(miss_c)
`ifdef RAMCTL_WR_PROTECT_EN
    , .wp(1'b0), .usr_err(err_c)
`endif
  );

  // Synchronous RAM model: read data appears one cycle after the address.
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Cycle index since the last release of clr; mirrors the prescaler count.
  always @(posedge clk or posedge clr) begin
    if (clr) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    int n = 0;
    while (cyc != c && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reach_cycle", cyc, c);
  endtask

  task automatic goto_phase4();
    int n = 0;
    while ((cyc % 16) != 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_phase4", cyc % 16, 4);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One user transaction started well clear of the scan slot: req in cycle 4, ack in cycle 7.
  task automatic run_user(input vec_t v);
    logic exp_we;
    exp_we = v.we && !wp_drv;
    goto_phase4();
    usr_req = 1'b1; usr_we = v.we; usr_addr = v.addr; usr_wdata = v.wdata;
    @(negedge clk);
    check("acc_we", ram_we, exp_we);
    check("acc_addr", ram_addr, v.addr);
    if (exp_we) check("acc_din", ram_din, v.wdata);
    check("acc_noack", usr_ack, 1'b0);
    @(negedge clk);
    check("wait_we", ram_we, 1'b0);
    check("wait_noack", usr_ack, 1'b0);
    @(negedge clk);
    check("ack", usr_ack, 1'b1);
    check("rdata", usr_rdata, v.exp_rdata);
    check("addr_hold", ram_addr, v.addr);
`ifdef RAMCTL_WR_PROTECT_EN
    check("usr_err_ack", usr_err, v.we && wp_drv);
`endif
    usr_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", usr_ack, 1'b0);
`ifdef RAMCTL_WR_PROTECT_EN
    check("usr_err_pulse", usr_err, 1'b0);
`endif
  endtask

  vec_t vt [10];
  logic [3:0] exp_an   [5];
  logic [7:0] exp_data [5];

  initial begin
    int changes;
    int acks_b;
    logic [3:0] prev_an;

    vt[0] = '{1'b1, 4'h3, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 4'h3, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 4'h4, 8'h11, 8'hA5};
    vt[3] = '{1'b1, 4'h5, 8'h22, 8'hA5};
    vt[4] = '{1'b1, 4'h6, 8'h33, 8'hA5};
    vt[5] = '{1'b1, 4'h7, 8'h44, 8'hA5};
    vt[6] = '{1'b0, 4'h5, 8'h00, 8'h22};
    vt[7] = '{1'b0, 4'h0, 8'h00, 8'h00};
    vt[8] = '{1'b1, 4'hF, 8'h5A, 8'h00};
    vt[9] = '{1'b0, 4'hF, 8'h00, 8'h5A};
    exp_an[0] = 4'b1110; exp_data[0] = 8'h11;
    exp_an[1] = 4'b1101; exp_data[1] = 8'h22;
    exp_an[2] = 4'b1011; exp_data[2] = 8'h33;
    exp_an[3] = 4'b0111; exp_data[3] = 8'h44;
    exp_an[4] = 4'b1110; exp_data[4] = 8'h11;

    // Reset state and the first tick (cycle 15 -> display at 19).
    do_reset();
    check("rst_ack", usr_ack, 1'b0);
    check("rst_rdata", usr_rdata, 8'h00);
    check("rst_addr", ram_addr, 4'h0);
    check("rst_we", ram_we, 1'b0);
    check("rst_din", ram_din, 8'h00);
    check("rst_an", disp_an, 4'b1111);
    check("rst_ddata", disp_data, 8'h00);
    check("rst_miss", scan_miss, 1'b0);
    goto(18);
    check("an_before_scan", disp_an, 4'b1111);
    goto(19);
    check("an_first_scan", disp_an, 4'b1110);
    check("data_first_scan", disp_data, 8'h00);

    for (int i = 0; i < 10; i++) run_user(vt[i]);

    // Page 1 display sweep over five ticks, from a fresh scan index.
    disp_page = 2'b01;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      goto(19 + 16 * k);
      check("sweep_an", disp_an, exp_an[k]);
      check("sweep_data", disp_data, exp_data[k]);
    end
    check("sweep_miss", scan_miss, 1'b0);

    // Write request rising with scan_pend (cycle 96): scan runs in 97-98, user in 100-101.
    goto(96);
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 4'h8; usr_wdata = 8'h77;
    @(negedge clk);
    check("pend_scan_we", ram_we, 1'b0);
    check("pend_scan_addr", ram_addr, 4'h5);
    check("pend_noack1", usr_ack, 1'b0);
    @(negedge clk);
    check("pend_wait_we", ram_we, 1'b0);
    @(negedge clk);
    check("pend_an", disp_an, 4'b1101);
    check("pend_data", disp_data, 8'h22);
    check("pend_noack2", usr_ack, 1'b0);
    @(negedge clk);
    check("pend_usr_we", ram_we, 1'b1);
    check("pend_usr_addr", ram_addr, 4'h8);
    check("pend_usr_din", ram_din, 8'h77);
    @(negedge clk);
    check("pend_noack3", usr_ack, 1'b0);
    @(negedge clk);
    check("pend_ack", usr_ack, 1'b1);
    usr_req = 1'b0;
    run_user('{1'b0, 4'h8, 8'h00, 8'h77});

    // clr asserted in USR_WAIT aborts the read without an ack.
    goto_phase4();
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 4'h3;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    usr_req = 1'b0;
    #1;
    check("abort_ack", usr_ack, 1'b0);
    check("abort_rdata", usr_rdata, 8'h00);
    check("abort_addr", ram_addr, 4'h0);
    check("abort_an", disp_an, 4'b1111);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_noack", usr_ack, 1'b0);
      @(negedge clk);
    end
    run_user('{1'b0, 4'h3, 8'h00, 8'hA5});

`ifdef RAMCTL_WR_PROTECT_EN
    wp_drv = 1'b1;
    run_user('{1'b1, 4'h0, 8'hFF, 8'hA5});
    wp_drv = 1'b0;
    run_user('{1'b0, 4'h0, 8'h00, 8'h00});
`endif

    // Continuous read streams: DIV_BITS=3 keeps up, DIV_BITS=2 overruns.
    @(negedge clk);
    clr_s = 1'b0;
    check("stream_rst_miss_b", miss_b, 1'b0);
    check("stream_rst_miss_c", miss_c, 1'b0);
    changes = 0;
    acks_b  = 0;
    prev_an = an_b;
    for (int i = 1; i <= 104; i++) begin
      @(negedge clk);
      if (an_b != prev_an) changes++;
      prev_an = an_b;
      if (ack_b) acks_b++;
    end
    check("stream_scans_b", changes, 12);
    check("stream_acks_b", acks_b > 0, 1'b1);
    check("stream_miss_b", miss_b, 1'b0);
    check("stream_miss_c", miss_c, 1'b1);
    repeat (20) @(negedge clk);
    check("stream_miss_c_sticky", miss_c, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
